// File: rtl/wgt_pingpong_buf_pkg.sv
// Shared types for the weight ping-pong buffer: bank-state encoding, control struct, defaults.
package wgt_pingpong_buf_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 5;
  localparam int NV_W_DEF   = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Complete control state of the buffer; checkers bind to this struct.
  typedef struct packed {
    bank_state_e [1:0] st;
    logic              wr_sel;
    logic              rd_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '0;

  function automatic logic is_writable(bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic is_readable(bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_READING);
  endfunction

endpackage

// File: rtl/wgt_buf_bank.sv
// One weight bank: simple dual-port RAM, synchronous read, no reset on the array or read register.
module wgt_buf_bank
  import wgt_pingpong_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wgt_pingpong_buf.sv
// Two-bank weight buffer: img2col_weight fills one bank while the cube unit reads the other.
module wgt_pingpong_buf
  import wgt_pingpong_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int NV_W   = NV_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wgt_wr_en,
  input  logic [ADDR_W-1:0] wgt_wr_addr,
  input  logic [DATA_W-1:0] wgt_out,
  input  logic [NV_W-1:0]   num_valid,
  input  logic              wgt_wr_done,
  output logic              wr_bank_avail,
  output logic              rd_bank_rdy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_depth,
  output logic [NV_W-1:0]   rd_num_valid,
  input  logic              rd_release,
  output logic              wr_overflow,
  output logic              rd_underflow
);

  // Handshake: a write is taken only while wr_bank_avail is high and a read only
  // while rd_bank_rdy is high (these act as ready); rd_valid qualifies rd_data one
  // cycle after an accepted read. Requests without ready are dropped and flagged.

  ctrl_t             ctrl_q, ctrl_d;
  logic              wr_accept, rd_accept, done_fire, rel_fire;
  logic [ADDR_W:0]   depth_q [2];
  logic [NV_W-1:0]   nv_q [2];
  logic [ADDR_W:0]   wr_addr_p1;
  logic [DATA_W-1:0] bank_rdata [2];
  logic              rd_valid_q, rd_oor_q, rd_bank_q;
  logic [DATA_W-1:0] rd_hold_q, rd_fresh;

  // State register
  always_ff @(posedge clock) begin
    if (rst) ctrl_q <= CTRL_RESET;
    else     ctrl_q <= ctrl_d;
  end

  // Next-state logic
  always_comb begin
    ctrl_d = ctrl_q;
    for (int b = 0; b < 2; b++) begin
      case (ctrl_q.st[b])
        BANK_EMPTY:
          if (wr_accept && ctrl_q.wr_sel == 1'(b)) ctrl_d.st[b] = BANK_FILLING;
        BANK_FILLING:
          if (done_fire && ctrl_q.wr_sel == 1'(b)) ctrl_d.st[b] = BANK_FULL;
        BANK_FULL:
          if (rel_fire && ctrl_q.rd_sel == 1'(b))       ctrl_d.st[b] = BANK_EMPTY;
          else if (rd_accept && ctrl_q.rd_sel == 1'(b)) ctrl_d.st[b] = BANK_READING;
        BANK_READING:
          if (rel_fire && ctrl_q.rd_sel == 1'(b)) ctrl_d.st[b] = BANK_EMPTY;
        default: ;
      endcase
    end
    if (done_fire) ctrl_d.wr_sel = ~ctrl_q.wr_sel;
    if (rel_fire)  ctrl_d.rd_sel = ~ctrl_q.rd_sel;
  end

  // Output / qualifier logic
  always_comb begin
    wr_bank_avail = is_writable(ctrl_q.st[ctrl_q.wr_sel]);
    rd_bank_rdy   = is_readable(ctrl_q.st[ctrl_q.rd_sel]);
    wr_accept     = wgt_wr_en && wr_bank_avail;
    rd_accept     = rd_en && rd_bank_rdy;
    // A done on a bank that never received a row is ignored.
    done_fire     = wgt_wr_done && (ctrl_q.st[ctrl_q.wr_sel] == BANK_FILLING);
    rel_fire      = rd_release && rd_bank_rdy;
  end

  assign wr_addr_p1 = {1'b0, wgt_wr_addr} + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        depth_q[b] <= '0;
        nv_q[b]    <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rel_fire && ctrl_q.rd_sel == 1'(b)) begin
          depth_q[b] <= '0;
          nv_q[b]    <= '0;
        end else if (wr_accept && ctrl_q.wr_sel == 1'(b)) begin
          if (wr_addr_p1 > depth_q[b]) depth_q[b] <= wr_addr_p1;
          nv_q[b] <= num_valid;
        end
      end
    end
  end

  assign rd_depth     = depth_q[ctrl_q.rd_sel];
  assign rd_num_valid = nv_q[ctrl_q.rd_sel];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    wgt_buf_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_bank (
      .clock(clock),
      .we   (wr_accept && ctrl_q.wr_sel == 1'(g)),
      .waddr(wgt_wr_addr),
      .wdata(wgt_out),
      .re   (rd_accept && ctrl_q.rd_sel == 1'(g)),
      .raddr(rd_addr),
      .rdata(bank_rdata[g])
    );
  end

  // Read side: bank and out-of-range decision are registered alongside the RAM read.
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_oor_q  <= ({1'b0, rd_addr} >= rd_depth);
        rd_bank_q <= ctrl_q.rd_sel;
      end
      if (rd_valid_q) rd_hold_q <= rd_fresh;
    end
  end

  always_comb begin
    rd_fresh = rd_oor_q ? '0 : bank_rdata[rd_bank_q];
    rd_data  = rd_valid_q ? rd_fresh : rd_hold_q;
  end

  assign rd_valid = rd_valid_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wgt_wr_en && !wr_bank_avail) wr_overflow  <= 1'b1;
      if (rd_en && !rd_bank_rdy)       rd_underflow <= 1'b1;
    end
  end

endmodule
